// File: rtl/syndrome_engine.sv
// Reed-Solomon syndrome engine: P symbols per beat, NSYN syndromes over GF(2^8) (poly 0x11D).
// Beats are framed with sop/eop; one registered result per codeword with valid/ready hand-off.
module syndrome_engine #(
  parameter int unsigned P         = 16,
  parameter int unsigned NSYN      = 16,
  parameter int unsigned FCR       = 0,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [P*8-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NSYN*8-1:0] out_syn,
  output logic              out_zero,
  output logic [7:0]        out_beats,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [255*8-1:0] build_pow();
    logic [255*8-1:0] t;
    logic [7:0]       v;
    t = '0;
    v = 8'h01;
    for (int unsigned e = 0; e < 255; e++) begin
      t[e*8 +: 8] = v;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    end
    return t;
  endfunction

  localparam logic [255*8-1:0] POW_TBL = build_pow();

  // Exponents are compile-time constants at every call site, so each product folds to an XOR network.
  function automatic logic [7:0] alpha_pow(input int unsigned e);
    return POW_TBL[(e % 255)*8 +: 8];
  endfunction

  state_t             state;
  logic [NSYN*8-1:0]  acc;
  logic [NSYN*8-1:0]  acc_next;
  logic [7:0]         beat_cnt;
  logic [7:0]         cnt_inc;
  logic [7:0]         s;
  logic               accept;

  assign in_ready = (state != DONE) || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = in_sop ? 8'd1 : beat_cnt + 8'd1;

  // A sop beat folds into a zero accumulator, so stale partial frames never leak into a result.
  always_comb begin
    acc_next = '0;
    s        = '0;
    for (int unsigned k = 0; k < NSYN; k++) begin
      s = in_sop ? 8'h00 : acc[k*8 +: 8];
      s = gf_mul(s, alpha_pow((FCR + k) * P));
      for (int unsigned j = 0; j < P; j++) begin
        s = s ^ gf_mul(in_data[j*8 +: 8], alpha_pow((FCR + k) * (P - 1 - j)));
      end
      acc_next[k*8 +: 8] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_syn   <= '0;
      out_zero  <= 1'b0;
      out_beats <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        if (!in_sop && state != ACCUM) begin
          // Orphan continuation beat: dropped; any held result was consumed this cycle.
          state     <= IDLE;
          out_valid <= 1'b0;
          frame_err <= 1'b1;
        end else begin
          acc      <= acc_next;
          beat_cnt <= cnt_inc;
          if (in_sop && state == ACCUM) frame_err <= 1'b1;
          if (in_eop) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_syn   <= acc_next;
            out_zero  <= (acc_next == '0);
            out_beats <= cnt_inc;
          end else if (cnt_inc == MAX_CNT) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            state     <= ACCUM;
            out_valid <= 1'b0;
          end
        end
      end else if (state == DONE && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_syndrome_engine.sv
// Randomised scoreboard bench for syndrome_engine: a symbol-serial log/antilog GF model
// predicts each codeword's syndromes; a negedge monitor pops and compares every delivered result.
module tb_syndrome_engine;
  localparam int P = 16;
  localparam int NSYN = 16;
  localparam int FCR = 0;
  localparam int MAX_BEATS = 16;

  typedef struct packed {
    logic [NSYN*8-1:0] syn;
    logic [7:0]        beats;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic [P*8-1:0]    in_data = '0;
  logic              out_ready = 1'b1;
  logic              in_ready;
  logic              out_valid;
  logic [NSYN*8-1:0] out_syn;
  logic              out_zero;
  logic [7:0]        out_beats;
  logic              frame_err;

  syndrome_engine #(.P(P), .NSYN(NSYN), .FCR(FCR), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_syn(out_syn), .out_zero(out_zero), .out_beats(out_beats), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int n_res = 0;
  int n_err_seen = 0;
  int n_err_exp = 0;
  int cyc = 0;
  int lat_at = -1;
  bit rdy_rand = 1'b0;
  bit held = 1'b0;
  logic [NSYN*8+8:0] held_val;

  logic [7:0] gexp [0:509];
  int         glog [0:255];
  logic [7:0] sym_q [$];
  exp_t       exp_q [$];
  bit         in_frame = 1'b0;
  int         frame_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[glog[a] + glog[b]];
  endfunction

  function automatic logic [NSYN*8-1:0] model_syn();
    logic [NSYN*8-1:0] r;
    r = '0;
    for (int k = 0; k < NSYN; k++) begin
      logic [7:0] sv;
      logic [7:0] a;
      sv = 8'h00;
      a = gexp[(FCR + k) % 255];
      foreach (sym_q[i]) sv = gmul(sv, a) ^ sym_q[i];
      r[k*8 +: 8] = sv;
    end
    return r;
  endfunction

  task automatic model_accept(input bit sop, input bit eop, input logic [P*8-1:0] d);
    exp_t e;
    if (!sop && !in_frame) begin
      n_err_exp++;
      return;
    end
    if (sop) begin
      if (in_frame) n_err_exp++;
      sym_q.delete();
      frame_cnt = 0;
      in_frame = 1'b1;
    end
    frame_cnt++;
    for (int j = 0; j < P; j++) sym_q.push_back(d[j*8 +: 8]);
    if (eop) begin
      e.syn = model_syn();
      e.beats = 8'(frame_cnt);
      exp_q.push_back(e);
      in_frame = 1'b0;
      lat_at = cyc + 1;
    end else if (frame_cnt == MAX_BEATS) begin
      n_err_exp++;
      in_frame = 1'b0;
    end
  endtask

  // Called and returns at posedge+1; the beat is held until a negedge sees in_ready.
  task automatic send_beat(input bit sop, input bit eop, input logic [P*8-1:0] d, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_sop = sop;
    in_eop = eop;
    in_data = d;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles, required 1", waits);
    end else begin
      model_accept(sop, eop, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    in_frame = 1'b0;
    held = 1'b0;
    lat_at = -1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P*8-1:0] rand_beat();
    logic [P*8-1:0] d;
    for (int j = 0; j < P; j++) d[j*8 +: 8] = 8'($urandom);
    return d;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (frame_err) n_err_seen++;
      if (lat_at == cyc) chk("latency_out_valid", out_valid, 1);
      if (out_valid) begin
        if (held) chk("hold_stable", {out_syn, out_zero, out_beats}, held_val);
        if (out_ready) begin
          held = 1'b0;
          n_res++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_result: got out_valid=1 with beats %0d, required no result", out_beats);
          end else begin
            e = exp_q.pop_front();
            chk("result_syn", out_syn, e.syn);
            chk("result_beats", out_beats, e.beats);
            chk("result_zero", out_zero, (e.syn == '0));
          end
        end else begin
          held = 1'b1;
          held_val = {out_syn, out_zero, out_beats};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int w;
    int e0;
    int r0;
    int len;
    int sel;
    logic [P*8-1:0] d;
    logic [NSYN*8-1:0] cap;
    int v;

    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = 8'(v);
      gexp[i + 255] = 8'(v);
      glog[v] = i;
      v = v << 1;
      if ((v & 256) != 0) v = v ^ 285;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_syn", out_syn, 0);
    chk("reset_out_zero", out_zero, 0);
    chk("reset_out_beats", out_beats, 0);
    chk("reset_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 16 all-zero beats
    for (int b = 0; b < 16; b++) send_beat(b == 0, b == 15, '0, w);
    @(negedge clk);
    chk("zero16_valid", out_valid, 1);
    chk("zero16_syn", out_syn, 0);
    chk("zero16_zero", out_zero, 1);
    chk("zero16_beats", out_beats, 16);
    @(posedge clk);
    #1;

    // Unit symbol at degree 0: every syndrome is 1
    d = '0;
    d[(P-1)*8 +: 8] = 8'h01;
    send_beat(1'b1, 1'b1, d, w);
    @(negedge clk);
    chk("deg0_syn", out_syn, {NSYN{8'h01}});
    chk("deg0_zero", out_zero, 0);
    chk("deg0_beats", out_beats, 1);
    @(posedge clk);
    #1;

    // Unit symbol at degree 1: S_k = alpha^k
    d = '0;
    d[(P-2)*8 +: 8] = 8'h01;
    send_beat(1'b1, 1'b1, d, w);
    @(negedge clk);
    chk("deg1_s0", out_syn[0*8 +: 8], 8'h01);
    chk("deg1_s1", out_syn[1*8 +: 8], 8'h02);
    chk("deg1_s2", out_syn[2*8 +: 8], 8'h04);
    chk("deg1_s3", out_syn[3*8 +: 8], 8'h08);
    chk("deg1_s8", out_syn[8*8 +: 8], 8'h1D);
    @(posedge clk);
    #1;

    // Back-pressure hold, then release together with a new sop beat
    out_ready = 1'b0;
    send_beat(1'b1, 1'b0, rand_beat(), w);
    send_beat(1'b0, 1'b1, rand_beat(), w);
    cap = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) cap = out_syn;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_syn_stable", out_syn, cap);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(1'b1, 1'b0, rand_beat(), w);
    chk("no_bubble_waits", w, 0);
    send_beat(1'b0, 1'b1, rand_beat(), w);
    idle(2);

    // sop in beat 5 abandons the frame; the 2-beat frame still reports correctly
    e0 = n_err_seen;
    r0 = n_res;
    for (int b = 0; b < 4; b++) send_beat(b == 0, 1'b0, rand_beat(), w);
    send_beat(1'b1, 1'b0, rand_beat(), w);
    send_beat(1'b0, 1'b1, rand_beat(), w);
    idle(3);
    chk("abort_err_pulses", n_err_seen - e0, 1);
    chk("abort_results", n_res - r0, 1);

    // Reset mid-frame, then a clean zero frame
    r0 = n_res;
    for (int b = 0; b < 3; b++) send_beat(b == 0, 1'b0, rand_beat(), w);
    do_reset();
    for (int b = 0; b < 16; b++) send_beat(b == 0, b == 15, '0, w);
    @(negedge clk);
    chk("rst_frame_zero", out_zero, 1);
    @(posedge clk);
    #1;
    idle(2);
    chk("rst_frame_results", n_res - r0, 1);

    // Overlong frame and orphan beat
    e0 = n_err_seen;
    r0 = n_res;
    for (int b = 0; b < MAX_BEATS; b++) send_beat(b == 0, 1'b0, rand_beat(), w);
    send_beat(1'b0, 1'b1, rand_beat(), w);
    idle(3);
    chk("overflow_orphan_errs", n_err_seen - e0, 2);
    chk("overflow_results", n_res - r0, 0);

    rdy_rand = 1'b1;
    for (int f = 0; f < 200; f++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        send_beat(1'b0, 1'($urandom_range(0, 1)), rand_beat(), w);
      end else begin
        len = (sel == 1) ? MAX_BEATS : $urandom_range(1, MAX_BEATS);
        for (int b = 0; b < len; b++) begin
          d = (sel == 3) ? '0 : rand_beat();
          send_beat(b == 0, (b == len - 1) && sel != 1 && sel != 2, d, w);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
      end
    end

    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frame_err_total", n_err_seen, n_err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/syndrome_engine.md
SYNDROME_ENGINE -- requirements
Module: syndrome_engine

Interface
REQ-001 SHALL have parameter P, default 16: GF(2^8) symbols per input beat, 1..32.
REQ-002 SHALL have parameter NSYN, default 16: number of syndromes computed, 2..32.
REQ-003 SHALL have parameter FCR, default 0: first consecutive root exponent, 0..254.
REQ-004 SHALL have parameter MAX_BEATS, default 16: maximum beats per codeword, 1..255.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-009 SHALL have port in_sop, input, 1 bit: the beat is the first beat of a codeword.
REQ-010 SHALL have port in_eop, input, 1 bit: the beat is the last beat of a codeword.
REQ-011 SHALL have port in_data, input, P*8 bits: the beat payload; symbol j is in_data[j*8+:8]; j=0 is the highest-degree symbol in the beat.
REQ-012 SHALL have port out_valid, output, 1 bit: a syndrome result is held.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port out_syn, output, NSYN*8 bits: syndrome S_k is out_syn[k*8+:8].
REQ-015 SHALL have port out_zero, output, 1 bit: every S_k is 0, meaning no detectable error.
REQ-016 SHALL have port out_beats, output, 8 bits: the beat count of the reported codeword.
REQ-017 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a framing violation.

Function
REQ-018 SHALL use GF(2^8) with primitive polynomial 0x11D and alpha = 0x02.
REQ-019 SHALL compute S_k = r(alpha^(FCR+k)) for k = 0..NSYN-1, where the codeword is streamed highest-degree symbol first.
REQ-020 SHALL treat a beat as accepted when in_valid && in_ready.
REQ-021 SHALL update the accumulator on each accepted beat by parallel Horner: S_k <- S_k*alpha^((FCR+k)*P) XOR sum over j of d_j*alpha^((FCR+k)*(P-1-j)).
REQ-022 SHALL, on an accepted sop beat, discard the prior accumulator value and use 0 in its place.
REQ-023 SHALL treat codewords whose length is not a multiple of P as valid; such codewords are left-padded with zero symbols in the first beat, which leaves the syndromes unchanged.
REQ-024 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-025 SHALL make FSM transitions on accepted beats as follows: IDLE with sop&!eop goes to ACCUM; any state with sop&eop goes to DONE; ACCUM with eop goes to DONE; DONE with out_ready and no beat goes to IDLE.
REQ-026 SHALL, in DONE with out_ready, accept a new sop beat in the same cycle, going to ACCUM or DONE (if eop); no bubble is inserted.
REQ-027 SHALL drive in_ready = (state != DONE) || out_ready.
REQ-028 SHALL make the result latency 1: eop accepted at cycle t gives out_valid=1 at t+1 with final out_syn, out_zero and out_beats.
REQ-029 SHALL hold out_syn, out_zero and out_beats stable while out_valid && !out_ready.
REQ-030 SHALL drop an accepted non-sop beat received in IDLE, and pulse frame_err.
REQ-031 SHALL, on an accepted sop beat received in ACCUM, abandon the partial codeword, pulse frame_err, and restart accumulation.
REQ-032 SHALL, when the beat counter reaches MAX_BEATS without eop, pulse frame_err, return to IDLE, and produce no result.
REQ-033 SHALL count beats from 1 at sop; out_beats reports that count.

Reset
REQ-034 SHALL, with rst high at a clock edge, clear state to IDLE, accumulator to 0, beat count to 0, out_valid to 0, out_syn to 0, out_zero to 0, out_beats to 0 and frame_err to 0.
REQ-035 SHALL drop a partial or held codeword when rst is asserted mid-operation; in_ready=1 in the first cycle after reset.

Verification
REQ-036 SHALL cover: 16 all-zero beats with sop/eop framing -> out_valid 1 cycle after eop, every S_k=0x00, out_zero=1, out_beats=16.
REQ-037 SHALL cover: FCR=0, one beat sop&eop with only symbol j=P-1 = 0x01 -> every S_k=0x01, out_zero=0, out_beats=1.
REQ-038 SHALL cover: FCR=0, one beat with only symbol j=P-2 = 0x01 -> S_0=0x01, S_1=0x02, S_2=0x04, S_3=0x08, S_8=0x1D.
REQ-039 SHALL cover: out_ready held low 3 cycles after a result -> out_syn unchanged, in_ready=0; out_ready=1 together with a new sop beat -> beat accepted that cycle.
REQ-040 SHALL cover: sop in beat 5 of a frame, then a clean 2-beat frame -> frame_err pulses once, and the single result equals the golden value of the 2-beat frame.
REQ-041 SHALL cover: rst asserted mid-frame, then a full zero frame -> no stale result, out_zero=1.
